// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one I2C register-transaction engine among NREQ requesters.
// Define I2C_ARB_TIMEOUT_EN to build the WAIT-state watchdog (limit set by TIMEOUT).
module i2c_cmd_arbiter #(
  parameter int NREQ    = 4,
  parameter int IW      = $clog2(NREQ),
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*7-1:0] req_dev_addr,
  input  logic [NREQ*8-1:0] req_mem_addr,
  input  logic [NREQ*8-1:0] req_wdata,
  input  logic [NREQ-1:0]   req_rw,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        rdata,
  output logic              err,
  output logic [IW-1:0]     grant_idx,
  output logic              busy,
  output logic              m_start,
  output logic [6:0]        m_dev_addr,
  output logic [7:0]        m_mem_addr,
  output logic [7:0]        m_wdata,
  output logic              m_rw,
  input  logic              m_busy,
  input  logic              m_done,
  input  logic              m_nack,
  input  logic [7:0]        m_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] last;
  logic [IW-1:0] sel_idx;
  logic [IW-1:0] cand;
  logic          sel_valid;
  logic          tmo;

  // First requesting index after the previous owner, wrapping modulo NREQ.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (!sel_valid && req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign busy    = (state != IDLE);
  assign m_start = (state == ISSUE) && !m_busy;

  always_comb begin
    ack = '0;
    if (state == RESP) ack[grant_idx] = 1'b1;
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  // Counter holds zero outside WAIT; tmo fires on the TIMEOUT-th WAIT cycle.
  always_ff @(posedge clk) begin
    if (reset || state != WAIT) wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + 1'b1;
  end

  assign tmo = (wait_cnt == CW'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last       <= IW'(NREQ - 1);
      grant_idx  <= '0;
      rdata      <= '0;
      err        <= 1'b0;
      m_dev_addr <= '0;
      m_mem_addr <= '0;
      m_wdata    <= '0;
      m_rw       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            grant_idx  <= sel_idx;
            m_dev_addr <= req_dev_addr[int'(sel_idx)*7 +: 7];
            m_mem_addr <= req_mem_addr[int'(sel_idx)*8 +: 8];
            m_wdata    <= req_wdata[int'(sel_idx)*8 +: 8];
            m_rw       <= req_rw[sel_idx];
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (!m_busy) state <= WAIT;
        end
        WAIT: begin
          // A completion in the same cycle as the watchdog takes precedence.
          if (m_done) begin
            rdata <= m_rdata;
            err   <= m_nack;
            state <= RESP;
          end else if (tmo) begin
            rdata <= '0;
            err   <= 1'b1;
            state <= RESP;
          end
        end
        default: begin
          last  <= grant_idx;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Bench for i2c_cmd_arbiter: directed and randomized transactions against a round-robin reference model.
module tb_i2c_cmd_arbiter;
  localparam int NREQ = 4;
  localparam int IW   = 2;
  localparam int TMO  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*7-1:0] req_dev_addr = '0;
  logic [NREQ*8-1:0] req_mem_addr = '0;
  logic [NREQ*8-1:0] req_wdata = '0;
  logic [NREQ-1:0]   req_rw = '0;
  logic [NREQ-1:0]   ack;
  logic [7:0]        rdata;
  logic              err;
  logic [IW-1:0]     grant_idx;
  logic              busy;
  logic              m_start;
  logic [6:0]        m_dev_addr;
  logic [7:0]        m_mem_addr;
  logic [7:0]        m_wdata;
  logic              m_rw;
  logic              m_busy = 1'b0;
  logic              m_done = 1'b0;
  logic              m_nack = 1'b0;
  logic [7:0]        m_rdata = '0;

  logic [6:0] dev [NREQ];
  logic [7:0] mem [NREQ];
  logic [7:0] wd  [NREQ];
  logic       rwv [NREQ];
  int last_model;
  int total = 0;
  int bad = 0;

  i2c_cmd_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_dev_addr(req_dev_addr), .req_mem_addr(req_mem_addr),
    .req_wdata(req_wdata), .req_rw(req_rw),
    .ack(ack), .rdata(rdata), .err(err), .grant_idx(grant_idx), .busy(busy),
    .m_start(m_start), .m_dev_addr(m_dev_addr), .m_mem_addr(m_mem_addr),
    .m_wdata(m_wdata), .m_rw(m_rw), .m_busy(m_busy), .m_done(m_done),
    .m_nack(m_nack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bus();
    for (int i = 0; i < NREQ; i++) begin
      req_dev_addr[i*7 +: 7] = dev[i];
      req_mem_addr[i*8 +: 8] = mem[i];
      req_wdata[i*8 +: 8]    = wd[i];
      req_rw[i]              = rwv[i];
    end
  endtask

  // Reference: first pending requester strictly after the last one served.
  function automatic int pick(input logic [NREQ-1:0] m);
    for (int k = 1; k <= NREQ; k++) begin
      int j = (last_model + k) % NREQ;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  // One full transaction; called at negedge+1 of an IDLE cycle with req already driven.
  task automatic run_txn(input int exp_idx, input int stall, input int lat,
                         input logic nack, input logic [7:0] rd, input logic drop);
    int n;
    logic [23:0] e_cmd;
    e_cmd  = {dev[exp_idx], mem[exp_idx], wd[exp_idx], rwv[exp_idx]};
    m_busy = (stall > 0);
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!busy && n < 20);
    chk("issue_latency", n, 1);
    if (!busy) return;
    chk("grant_idx", grant_idx, exp_idx);
    for (int i = 0; i < stall; i++) begin
      chk("start_while_busy", m_start, 0);
      m_done = 1'b1;
      @(negedge clk);
      m_done = 1'b0;
      if (i == stall - 1) m_busy = 1'b0;
      #1;
    end
    chk("m_start", m_start, 1);
    chk("cmd_at_start", {m_dev_addr, m_mem_addr, m_wdata, m_rw}, e_cmd);
    @(negedge clk);
    m_busy = 1'b1;
    if (drop) req[exp_idx] = 1'b0;
    dev[exp_idx] = 7'($urandom);
    mem[exp_idx] = 8'($urandom);
    wd[exp_idx]  = 8'($urandom);
    drive_bus();
    #1;
    for (int i = 0; i < lat; i++) begin
      chk("no_early_ack", ack, 0);
      chk("cmd_hold", {m_dev_addr, m_mem_addr, m_wdata, m_rw}, e_cmd);
      @(negedge clk); #1;
    end
    m_done  = 1'b1;
    m_nack  = nack;
    m_rdata = rd;
    #1;
    chk("no_ack_with_done", ack, 0);
    @(negedge clk);
    m_done  = 1'b0;
    m_nack  = 1'($urandom);
    m_rdata = 8'($urandom);
    #1;
    chk("ack", ack, 1 << exp_idx);
    chk("rdata", rdata, rd);
    chk("err", err, nack);
    last_model = exp_idx;
    @(negedge clk); #1;
    chk("ack_one_cycle", ack, 0);
    chk("idle_after_ack", busy, 0);
  endtask

  initial begin
    int rr_exp [6];
    int e;
    logic [NREQ-1:0] mask;
    rr_exp = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < NREQ; i++) begin
      dev[i] = 7'($urandom); mem[i] = 8'($urandom); wd[i] = 8'($urandom); rwv[i] = 1'($urandom);
    end
    drive_bus();
    last_model = NREQ - 1;

    // Reset state, with requests pending during reset
    reset = 1'b1;
    req = 4'b1111;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_m_start", m_start, 0);
    chk("rst_grant", grant_idx, 0);
    chk("rst_rdata_err", {rdata, err}, 0);
    chk("rst_cmd", {m_dev_addr, m_mem_addr, m_wdata, m_rw}, 0);
    reset = 1'b0;

    // Round-robin with all requesters held high
    for (int i = 0; i < 6; i++) run_txn(rr_exp[i], 0, 3, 1'b0, 8'($urandom), 1'b0);

    // Directed write from requester 0
    req = 4'b0001;
    dev[0] = 7'h50; mem[0] = 8'h10; wd[0] = 8'hA5; rwv[0] = 1'b0;
    drive_bus();
    run_txn(0, 0, 2, 1'b0, 8'h00, 1'b1);

    // Directed read from requester 2
    req = 4'b0100;
    rwv[2] = 1'b1;
    drive_bus();
    run_txn(2, 0, 1, 1'b0, 8'h3C, 1'b0);

    // Engine busy for 5 cycles in ISSUE, then NACK
    req = 4'b1000;
    run_txn(3, 5, 2, 1'b1, 8'h5A, 1'b0);

`ifdef I2C_ARB_TIMEOUT_EN
    // Watchdog: engine never completes
    req = 4'b0010;
    m_busy = 1'b0;
    @(negedge clk); #1;
    chk("tmo_start", m_start, 1);
    @(negedge clk);
    req = '0;
    m_busy = 1'b1;
    #1;
    for (int i = 0; i < TMO; i++) begin
      chk("tmo_no_ack", ack, 0);
      @(negedge clk); #1;
    end
    chk("tmo_ack", ack, 4'b0010);
    chk("tmo_err", err, 1);
    chk("tmo_rdata", rdata, 0);
    last_model = 1;
    @(negedge clk); #1;
    chk("tmo_idle", busy, 0);
`endif

    // Stray completion while idle
    req = '0;
    m_done = 1'b1;
    m_nack = 1'b1;
    @(negedge clk);
    m_done = 1'b0;
    #1;
    chk("stray_ack", ack, 0);
    chk("stray_busy", busy, 0);
    @(negedge clk); #1;
    chk("stray_ack2", ack, 0);

    // Reset in WAIT: serve 1, start 3, reset, then requester 0 must win
    req = 4'b0010;
    run_txn(1, 0, 1, 1'b0, 8'h11, 1'b0);
    req = 4'b1000;
    m_busy = 1'b0;
    @(negedge clk); #1;
    chk("pre_rst_grant", grant_idx, 3);
    @(negedge clk);
    m_busy = 1'b1;
    #1;
    chk("pre_rst_busy", busy, 1);
    @(negedge clk);
    reset = 1'b1;
    req = 4'b1001;
    m_busy = 1'b0;
    #1;
    @(negedge clk); #1;
    chk("wrst_busy", busy, 0);
    chk("wrst_ack", ack, 0);
    chk("wrst_m_start", m_start, 0);
    chk("wrst_grant", grant_idx, 0);
    reset = 1'b0;
    last_model = NREQ - 1;
    run_txn(0, 0, 1, 1'b0, 8'h22, 1'b0);

    // Randomized traffic against the reference model
    for (int t = 0; t < 24; t++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        dev[i] = 7'($urandom); mem[i] = 8'($urandom); wd[i] = 8'($urandom); rwv[i] = 1'($urandom);
      end
      drive_bus();
      req = mask;
      e = pick(mask);
      run_txn(e, $urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom), 8'($urandom), 1'($urandom));
    end
    req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
